// File: rtl/sd_card_fsm_if.sv
// -----------------------------------------------------------------------------
// sd_card_fsm_if
// Command/response bundle between the host-facing CMD-line logic and the
// card-side command state machine.
//   master : drives decoded commands and idata_done, observes responses.
//   slave  : the state machine (sd_card_fsm).
// Signals:
//   icmd_valid/icrc_err/icmd_index/icmd_arg : decoded command frame
//   idata_done                              : data path finished programming
//   oresp_start/oresp_type/oresp            : response to transmit
//   ostart_rd/ostart_wr/ostop               : data-path control pulses
//   oblock_addr/obus4/ocard_state           : card status
// -----------------------------------------------------------------------------
interface sd_card_fsm_if;
    logic        icmd_valid;
    logic        icrc_err;
    logic [5:0]  icmd_index;
    logic [31:0] icmd_arg;
    logic        idata_done;
    logic        oresp_start;
    logic [2:0]  oresp_type;
    logic [31:0] oresp;
    logic        ostart_rd;
    logic        ostart_wr;
    logic        ostop;
    logic [31:0] oblock_addr;
    logic        obus4;
    logic [3:0]  ocard_state;

    modport master (
        output icmd_valid, icrc_err, icmd_index, icmd_arg, idata_done,
        input  oresp_start, oresp_type, oresp, ostart_rd, ostart_wr, ostop,
               oblock_addr, obus4, ocard_state
    );

    modport slave (
        input  icmd_valid, icrc_err, icmd_index, icmd_arg, idata_done,
        output oresp_start, oresp_type, oresp, ostart_rd, ostart_wr, ostop,
               oblock_addr, obus4, ocard_state
    );
endinterface

// File: rtl/sd_card_fsm.sv
// -----------------------------------------------------------------------------
// sd_card_fsm
// Card-side SD command state machine (SDHC block addressing). Decodes each
// command on its icmd_valid cycle; response, data-path pulses and the new
// card state are all registered and appear on the following cycle.
// Ports:
//   iclk, irst : clock, asynchronous active-high reset
//   bus        : sd_card_fsm_if.slave (commands in, responses/status out)
// Optional feature macro: SD_CARD_CMD13_EN (CMD13 SEND_STATUS support;
// when undefined CMD13 is illegal).
// -----------------------------------------------------------------------------
module sd_card_fsm #(
    parameter logic [15:0] RCA             = 16'h1234,
    parameter int unsigned ACMD41_BUSY_CNT = 2,
    parameter logic [31:0] CAPACITY_BLK    = 32'h0040_0000
) (
    input  logic          iclk,
    input  logic          irst,
    sd_card_fsm_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_READY = 4'd1,
        S_IDENT = 4'd2,
        S_STBY  = 4'd3,
        S_TRAN  = 4'd4,
        S_DATA  = 4'd5,
        S_RCV   = 4'd6,
        S_PRG   = 4'd7,
        S_INA   = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        R_NONE  = 3'd0,
        R_R1    = 3'd1,
        R_R1B   = 3'd2,
        R_R2CID = 3'd3,
        R_R3    = 3'd4,
        R_R2CSD = 3'd5,
        R_R6    = 3'd6,
        R_R7    = 3'd7
    } resp_t;

    localparam logic [7:0] BUSY_MAX = 8'(ACMD41_BUSY_CNT);

    state_t      state_q;
    resp_t       resp_type_q;
    logic        resp_start_q;
    logic [31:0] resp_q;
    logic        start_rd_q;
    logic        start_wr_q;
    logic        stop_q;
    logic [31:0] blk_q;
    logic        bus4_q;
    logic [7:0]  busy_cnt_q;
    logic        app_q;
    logic        crc_q;
    logic        ill_q;

    logic [31:0] st_w;
    logic        rca_match;
    logic        prg_keep;

    // R1 card status as seen at command receipt
    assign st_w = {1'b0, 7'd0, crc_q, ill_q, 9'd0, state_q, 1'b1, 2'd0, app_q, 5'd0};
    assign rca_match = (bus.icmd_arg[31:16] == RCA);
    // Commands that take the card out of prg somewhere other than tran
    assign prg_keep = bus.icmd_valid && !bus.icrc_err &&
                      ((bus.icmd_index == 6'd0) || ((bus.icmd_index == 6'd15) && rca_match));

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q      <= S_IDLE;
            resp_start_q <= 1'b0;
            resp_type_q  <= R_NONE;
            resp_q       <= '0;
            start_rd_q   <= 1'b0;
            start_wr_q   <= 1'b0;
            stop_q       <= 1'b0;
            blk_q        <= '0;
            bus4_q       <= 1'b0;
            busy_cnt_q   <= '0;
            app_q        <= 1'b0;
            crc_q        <= 1'b0;
            ill_q        <= 1'b0;
        end else begin
            resp_start_q <= 1'b0;
            start_rd_q   <= 1'b0;
            start_wr_q   <= 1'b0;
            stop_q       <= 1'b0;
            if (bus.icmd_valid && (state_q != S_INA)) begin
                if (bus.icrc_err) begin
                    crc_q <= 1'b1;
                end else begin
                    app_q <= 1'b0;
                    if (app_q && (bus.icmd_index == 6'd41)) begin
                        if (state_q == S_IDLE) begin
                            resp_start_q <= 1'b1;
                            resp_type_q  <= R_R3;
                            if (bus.icmd_arg[21:20] == 2'b00) begin
                                resp_q  <= '0;
                                state_q <= S_INA;
                            end else if (busy_cnt_q < BUSY_MAX) begin
                                resp_q     <= 32'h0030_0000;
                                busy_cnt_q <= busy_cnt_q + 8'd1;
                            end else begin
                                resp_q  <= 32'hC030_0000;
                                state_q <= S_READY;
                            end
                        end else begin
                            ill_q <= 1'b1;
                        end
                    end else if (app_q && (bus.icmd_index == 6'd6)) begin
                        if (state_q == S_TRAN) begin
                            resp_start_q <= 1'b1;
                            resp_type_q  <= R_R1;
                            resp_q       <= st_w;
                            crc_q        <= 1'b0;
                            ill_q        <= 1'b0;
                            bus4_q       <= (bus.icmd_arg[1:0] == 2'b10);
                        end else begin
                            ill_q <= 1'b1;
                        end
                    end else begin
                        case (bus.icmd_index)
                            6'd0: begin
                                state_q    <= S_IDLE;
                                crc_q      <= 1'b0;
                                ill_q      <= 1'b0;
                                busy_cnt_q <= '0;
                                bus4_q     <= 1'b0;
                            end
                            6'd2: begin
                                if (state_q == S_READY) begin
                                    resp_start_q <= 1'b1;
                                    resp_type_q  <= R_R2CID;
                                    resp_q       <= '0;
                                    state_q      <= S_IDENT;
                                end else ill_q <= 1'b1;
                            end
                            6'd3: begin
                                if ((state_q == S_IDENT) || (state_q == S_STBY)) begin
                                    resp_start_q <= 1'b1;
                                    resp_type_q  <= R_R6;
                                    resp_q       <= {RCA, st_w[23], st_w[22], st_w[19], st_w[12:0]};
                                    crc_q        <= 1'b0;
                                    ill_q        <= 1'b0;
                                    state_q      <= S_STBY;
                                end else ill_q <= 1'b1;
                            end
                            6'd7: begin
                                if (state_q == S_STBY) begin
                                    if (rca_match) begin
                                        resp_start_q <= 1'b1;
                                        resp_type_q  <= R_R1B;
                                        resp_q       <= st_w;
                                        crc_q        <= 1'b0;
                                        ill_q        <= 1'b0;
                                        state_q      <= S_TRAN;
                                    end
                                end else if ((state_q == S_TRAN) || (state_q == S_DATA) ||
                                             (state_q == S_PRG)) begin
                                    if (!rca_match) state_q <= S_STBY;
                                    else            ill_q   <= 1'b1;
                                end else ill_q <= 1'b1;
                            end
                            6'd8: begin
                                if (state_q == S_IDLE) begin
                                    if (bus.icmd_arg[11:8] == 4'd1) begin
                                        resp_start_q <= 1'b1;
                                        resp_type_q  <= R_R7;
                                        resp_q       <= {20'd0, bus.icmd_arg[11:0]};
                                    end
                                end else ill_q <= 1'b1;
                            end
                            6'd9: begin
                                if (state_q == S_STBY) begin
                                    if (rca_match) begin
                                        resp_start_q <= 1'b1;
                                        resp_type_q  <= R_R2CSD;
                                        resp_q       <= '0;
                                    end
                                end else ill_q <= 1'b1;
                            end
                            6'd12: begin
                                if ((state_q == S_DATA) || (state_q == S_RCV)) begin
                                    resp_start_q <= 1'b1;
                                    resp_type_q  <= R_R1B;
                                    resp_q       <= st_w;
                                    crc_q        <= 1'b0;
                                    ill_q        <= 1'b0;
                                    stop_q       <= 1'b1;
                                    state_q      <= (state_q == S_DATA) ? S_TRAN : S_PRG;
                                end else ill_q <= 1'b1;
                            end
`ifdef SD_CARD_CMD13_EN
                            6'd13: begin
                                if ((state_q == S_STBY) || (state_q == S_TRAN) ||
                                    (state_q == S_DATA) || (state_q == S_RCV) ||
                                    (state_q == S_PRG)) begin
                                    if (rca_match) begin
                                        resp_start_q <= 1'b1;
                                        resp_type_q  <= R_R1;
                                        resp_q       <= st_w;
                                        crc_q        <= 1'b0;
                                        ill_q        <= 1'b0;
                                    end
                                end else ill_q <= 1'b1;
                            end
`endif
                            6'd15: begin
                                if (state_q == S_IDLE) ill_q <= 1'b1;
                                else if (rca_match)    state_q <= S_INA;
                            end
                            6'd18, 6'd25: begin
                                if (state_q == S_TRAN) begin
                                    resp_start_q <= 1'b1;
                                    resp_type_q  <= R_R1;
                                    crc_q        <= 1'b0;
                                    ill_q        <= 1'b0;
                                    if (bus.icmd_arg >= CAPACITY_BLK) begin
                                        resp_q <= st_w | 32'h8000_0000;
                                    end else begin
                                        resp_q <= st_w;
                                        blk_q  <= bus.icmd_arg;
                                        if (bus.icmd_index == 6'd18) begin
                                            start_rd_q <= 1'b1;
                                            state_q    <= S_DATA;
                                        end else begin
                                            start_wr_q <= 1'b1;
                                            state_q    <= S_RCV;
                                        end
                                    end
                                end else ill_q <= 1'b1;
                            end
                            6'd55: begin
                                if ((state_q == S_IDLE) || (state_q == S_READY) || rca_match) begin
                                    resp_start_q <= 1'b1;
                                    resp_type_q  <= R_R1;
                                    resp_q       <= st_w | 32'h0000_0020;
                                    crc_q        <= 1'b0;
                                    ill_q        <= 1'b0;
                                    app_q        <= 1'b1;
                                end
                            end
                            default: ill_q <= 1'b1;
                        endcase
                    end
                end
            end
            // Programming completion overrides the command's own transition
            // except where the command forces idle/ina.
            if ((state_q == S_PRG) && bus.idata_done && !prg_keep) state_q <= S_TRAN;
        end
    end

    assign bus.oresp_start = resp_start_q;
    assign bus.oresp_type  = resp_type_q;
    assign bus.oresp       = resp_q;
    assign bus.ostart_rd   = start_rd_q;
    assign bus.ostart_wr   = start_wr_q;
    assign bus.ostop       = stop_q;
    assign bus.oblock_addr = blk_q;
    assign bus.obus4       = bus4_q;
    assign bus.ocard_state = state_q;

endmodule

// File: tb/tb_sd_card_fsm.sv
module tb_sd_card_fsm;

    localparam logic [31:0] RCAARG = 32'h1234_0000;
    localparam logic [31:0] ALL    = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        start;
        logic [2:0]  rt;
        logic [31:0] resp;
        logic        rd;
        logic        wr;
        logic        stop;
        logic [3:0]  st;
        logic        bus4;
        logic [31:0] blk;
    } obs_t;

    typedef struct {
        string       name;
        obs_t        o;
        logic [31:0] mask;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    exp_t exp_q[$];
    obs_t obs_q[$];

    // bench model of held outputs
    logic [2:0]  m_type;
    logic [31:0] m_resp;
    logic        m_bus4;
    logic [31:0] m_blk;

    sd_card_fsm_if bus ();

    sd_card_fsm #(
        .RCA             (16'h1234),
        .ACMD41_BUSY_CNT (2),
        .CAPACITY_BLK    (32'h0040_0000)
    ) dut (
        .iclk (clk),
        .irst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.start = bus.oresp_start;
        o.rt    = bus.oresp_type;
        o.resp  = bus.oresp;
        o.rd    = bus.ostart_rd;
        o.wr    = bus.ostart_wr;
        o.stop  = bus.ostop;
        o.st    = bus.ocard_state;
        o.bus4  = bus.obus4;
        o.blk   = bus.oblock_addr;
        return o;
    endfunction

    // Drive one cycle of stimulus, push the expected result, capture the
    // registered outputs one cycle later.
    task automatic issue(input string name, input logic v, input logic [5:0] idx,
                         input logic [31:0] arg, input logic crc, input logic done,
                         input logic rsp, input logic [2:0] rt, input logic [31:0] rv,
                         input logic [31:0] mask, input logic rd, input logic wr,
                         input logic stop, input logic [3:0] st);
        exp_t e;
        e.name = name;
        e.mask = rsp ? mask : ALL;
        if (rsp) begin
            m_type = rt;
            m_resp = rv;
        end
        e.o.start = rsp;
        e.o.rt    = m_type;
        e.o.resp  = m_resp;
        e.o.rd    = rd;
        e.o.wr    = wr;
        e.o.stop  = stop;
        e.o.st    = st;
        e.o.bus4  = m_bus4;
        e.o.blk   = m_blk;
        exp_q.push_back(e);
        @(negedge clk);
        bus.icmd_valid = v;
        bus.icmd_index = idx;
        bus.icmd_arg   = arg;
        bus.icrc_err   = crc;
        bus.idata_done = done;
        @(negedge clk);
        bus.icmd_valid = 1'b0;
        bus.icrc_err   = 1'b0;
        bus.idata_done = 1'b0;
        obs_q.push_back(sample());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.ocard_state, bus.oresp_type, bus.oresp, bus.oblock_addr, bus.obus4} !== '0) begin
            bad++;
            $display("FAIL reset_values got st=%0d type=%0d resp=%h blk=%h bus4=%b want all 0",
                     bus.ocard_state, bus.oresp_type, bus.oresp, bus.oblock_addr, bus.obus4);
        end
        total++;
        if ({bus.oresp_start, bus.ostart_rd, bus.ostart_wr, bus.ostop} !== 4'b0) begin
            bad++;
            $display("FAIL reset_pulses got %b want 0000",
                     {bus.oresp_start, bus.ostart_rd, bus.ostart_wr, bus.ostop});
        end
        rst = 1'b0;
        m_type = 3'd0; m_resp = '0; m_bus4 = 1'b0; m_blk = '0;
        @(negedge clk);
    endtask

    task automatic test_init();
        exp_t e; obs_t a;
        issue("cmd8_ok",   1, 8,  32'h0000_01AA, 0, 0, 1, 7, 32'h0000_01AA, ALL, 0, 0, 0, 0);
        issue("cmd8_bad",  1, 8,  32'h0000_02AA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue("cmd55_a",   1, 55, 32'h0,         0, 0, 1, 1, 32'h0000_0120, ALL, 0, 0, 0, 0);
        issue("acmd41_b1", 1, 41, 32'h8030_0000, 0, 0, 1, 4, 32'h0030_0000, ALL, 0, 0, 0, 0);
        issue("cmd55_b",   1, 55, 32'h0,         0, 0, 1, 1, 32'h0000_0120, ALL, 0, 0, 0, 0);
        issue("acmd41_b2", 1, 41, 32'h8030_0000, 0, 0, 1, 4, 32'h0030_0000, ALL, 0, 0, 0, 0);
        issue("cmd55_c",   1, 55, 32'h0,         0, 0, 1, 1, 32'h0000_0120, ALL, 0, 0, 0, 0);
        issue("acmd41_rdy",1, 41, 32'h8030_0000, 0, 0, 1, 4, 32'hC030_0000, ALL, 0, 0, 0, 1);
        issue("cmd2_cid",  1, 2,  32'h0,         0, 0, 1, 3, 32'h0,         32'h0, 0, 0, 0, 2);
        issue("cmd3_r6",   1, 3,  32'h0,         0, 0, 1, 6, 32'h1234_0500, ALL, 0, 0, 0, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front();
            a.resp &= e.mask; e.o.resp &= e.mask;
            total++;
            if (a !== e.o) begin bad++; $display("FAIL %s got=%h want=%h", e.name, a, e.o); end
        end
    endtask

    task automatic test_tran();
        exp_t e; obs_t a;
        issue("cmd7_sel",  1, 7,  RCAARG,        0, 0, 1, 2, 32'h0000_0700, ALL, 0, 0, 0, 4);
        issue("cmd55_tr",  1, 55, RCAARG,        0, 0, 1, 1, 32'h0000_0920, ALL, 0, 0, 0, 4);
        m_bus4 = 1'b1;
        issue("acmd6_4b",  1, 6,  32'hFFFF_FFFE, 0, 0, 1, 1, 32'h0000_0920, ALL, 0, 0, 0, 4);
        issue("cmd7_desel",1, 7,  32'h0,         0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        issue("cmd7_resel",1, 7,  RCAARG,        0, 0, 1, 2, 32'h0000_0700, ALL, 0, 0, 0, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front();
            a.resp &= e.mask; e.o.resp &= e.mask;
            total++;
            if (a !== e.o) begin bad++; $display("FAIL %s got=%h want=%h", e.name, a, e.o); end
        end
    endtask

    task automatic test_read();
        exp_t e; obs_t a;
        m_blk = 32'h0000_1000;
        issue("cmd18_rd",  1, 18, 32'h0000_1000, 0, 0, 1, 1, 32'h0000_0900, ALL, 1, 0, 0, 5);
        issue("cmd12_rd",  1, 12, 32'h0,         0, 0, 1, 2, 32'h0000_0B00, ALL, 0, 0, 1, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front();
            a.resp &= e.mask; e.o.resp &= e.mask;
            total++;
            if (a !== e.o) begin bad++; $display("FAIL %s got=%h want=%h", e.name, a, e.o); end
        end
    endtask

    task automatic test_write();
        exp_t e; obs_t a;
        m_blk = 32'h0000_2000;
        issue("cmd25_wr",  1, 25, 32'h0000_2000, 0, 0, 1, 1, 32'h0000_0900, ALL, 0, 1, 0, 6);
        issue("cmd12_wr",  1, 12, 32'h0,         0, 0, 1, 2, 32'h0000_0D00, ALL, 0, 0, 1, 7);
        issue("data_done", 0, 0,  32'h0,         0, 1, 0, 0, 0, 0, 0, 0, 0, 4);
        issue("cmd18_oor", 1, 18, 32'h0040_0000, 0, 0, 1, 1, 32'h8000_0900, ALL, 0, 0, 0, 4);
        m_blk = 32'h003F_FFFF;
        issue("cmd18_last",1, 18, 32'h003F_FFFF, 0, 0, 1, 1, 32'h0000_0900, ALL, 1, 0, 0, 5);
        issue("cmd12_last",1, 12, 32'h0,         0, 0, 1, 2, 32'h0000_0B00, ALL, 0, 0, 1, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front();
            a.resp &= e.mask; e.o.resp &= e.mask;
            total++;
            if (a !== e.o) begin bad++; $display("FAIL %s got=%h want=%h", e.name, a, e.o); end
        end
    endtask

    task automatic test_errors();
        exp_t e; obs_t a;
        issue("cmd2_illegal", 1, 2,  32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        issue("ill_reported", 1, 55, RCAARG, 0, 0, 1, 1, 32'h0040_0920, ALL, 0, 0, 0, 4);
        m_bus4 = 1'b1;
        issue("ill_cleared",  1, 6,  32'h2,  0, 0, 1, 1, 32'h0000_0920, ALL, 0, 0, 0, 4);
        issue("crc_bad",      1, 55, RCAARG, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        issue("crc_reported", 1, 55, RCAARG, 0, 0, 1, 1, 32'h0080_0920, ALL, 0, 0, 0, 4);
        m_bus4 = 1'b0;
        issue("acmd6_1b",     1, 6,  32'h0,  0, 0, 1, 1, 32'h0000_0920, ALL, 0, 0, 0, 4);
`ifdef SD_CARD_CMD13_EN
        issue("cmd13_status", 1, 13, RCAARG, 0, 0, 1, 1, 32'h0000_0900, ALL, 0, 0, 0, 4);
        issue("cmd55_after13",1, 55, RCAARG, 0, 0, 1, 1, 32'h0000_0920, ALL, 0, 0, 0, 4);
`else
        issue("cmd13_illegal",1, 13, RCAARG, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        issue("cmd55_after13",1, 55, RCAARG, 0, 0, 1, 1, 32'h0040_0920, ALL, 0, 0, 0, 4);
`endif
        issue("acmd6_clr",    1, 6,  32'h0,  0, 0, 1, 1, 32'h0000_0920, ALL, 0, 0, 0, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front();
            a.resp &= e.mask; e.o.resp &= e.mask;
            total++;
            if (a !== e.o) begin bad++; $display("FAIL %s got=%h want=%h", e.name, a, e.o); end
        end
    endtask

    task automatic test_back_to_back_prg();
        exp_t e; obs_t a;
        m_blk = 32'h0000_0010;
        issue("cmd25_b2b",    1, 25, 32'h10,  0, 0, 1, 1, 32'h0000_0900, ALL, 0, 1, 0, 6);
        issue("cmd12_b2b",    1, 12, 32'h0,   0, 0, 1, 2, 32'h0000_0D00, ALL, 0, 0, 1, 7);
        issue("cmd55_in_prg", 1, 55, RCAARG,  0, 1, 1, 1, 32'h0000_0F20, ALL, 0, 0, 0, 4);
        m_bus4 = 1'b1;
        issue("acmd6_after",  1, 6,  32'h2,   0, 0, 1, 1, 32'h0000_0920, ALL, 0, 0, 0, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front();
            a.resp &= e.mask; e.o.resp &= e.mask;
            total++;
            if (a !== e.o) begin bad++; $display("FAIL %s got=%h want=%h", e.name, a, e.o); end
        end
    endtask

    task automatic test_reset_mid_rcv();
        exp_t e; obs_t a;
        m_blk = 32'h0000_0020;
        issue("cmd25_pre_rst", 1, 25, 32'h20, 0, 0, 1, 1, 32'h0000_0900, ALL, 0, 1, 0, 6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front();
            a.resp &= e.mask; e.o.resp &= e.mask;
            total++;
            if (a !== e.o) begin bad++; $display("FAIL %s got=%h want=%h", e.name, a, e.o); end
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.ocard_state, bus.obus4, bus.oresp_type, bus.oresp, bus.oblock_addr} !== '0) begin
            bad++;
            $display("FAIL async_reset got st=%0d bus4=%b type=%0d resp=%h blk=%h want all 0",
                     bus.ocard_state, bus.obus4, bus.oresp_type, bus.oresp, bus.oblock_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        m_type = 3'd0; m_resp = '0; m_bus4 = 1'b0; m_blk = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus.oresp_start, bus.ostart_rd, bus.ostart_wr, bus.ostop, bus.ocard_state} !== 8'h0) begin
                bad++;
                $display("FAIL post_reset_quiet cycle=%0d got pulses=%b st=%0d want 0000 st=0", i,
                         {bus.oresp_start, bus.ostart_rd, bus.ostart_wr, bus.ostop}, bus.ocard_state);
            end
        end
    endtask

    task automatic test_ina();
        exp_t e; obs_t a;
        issue("cmd55_ina",   1, 55, 32'h0, 0, 0, 1, 1, 32'h0000_0120, ALL, 0, 0, 0, 0);
        issue("acmd41_volt", 1, 41, 32'h0, 0, 0, 1, 4, 32'h0,         ALL, 0, 0, 0, 15);
        issue("cmd0_in_ina", 1, 0,  32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15);
        issue("cmd55_in_ina",1, 55, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = obs_q.pop_front();
            a.resp &= e.mask; e.o.resp &= e.mask;
            total++;
            if (a !== e.o) begin bad++; $display("FAIL %s got=%h want=%h", e.name, a, e.o); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.icmd_valid = 1'b0;
        bus.icrc_err   = 1'b0;
        bus.icmd_index = '0;
        bus.icmd_arg   = '0;
        bus.idata_done = 1'b0;
        m_type = 3'd0; m_resp = '0; m_bus4 = 1'b0; m_blk = '0;
        test_reset();
        test_init();
        test_tran();
        test_read();
        test_write();
        test_errors();
        test_back_to_back_prg();
        test_reset_mid_rcv();
        test_ina();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
